clic_exit_stack: RTL
====================

# clic_exit_stack

Interrupt exit/nesting unit for the N-CLIC core: the return-side counterpart of the CLIC dispatch path. On every interrupt entry it pushes the preempted priority level and resume PC; on every ISR return it pops them, supplying the PC and level the core resumes with. It also supports tail-chaining when an entry and a return coincide. It sits between `n_clic` (entry requests, current level) and the PC mux/register-file bank select in the core top.

## Interface
Parameters:
- `PrioWidth`, 3: width of a priority level; level 0 is thread mode.
- `PcWidth`, 32: resume-PC width.
- `Depth`, 2**PrioWidth - 1: stack entries; one per possible nesting step.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `entry_valid`  in  1  CLIC takes an interrupt this cycle.
- `entry_level`  in  PrioWidth  priority of the interrupt being taken.
- `entry_ret_pc`  in  PcWidth  PC of the next not-yet-executed instruction of the preempted context.
- `exit_req`  in  1  core executes an ISR return this cycle (jalr to the exit sentinel).
- `level_out`  out  PrioWidth  currently running level; drives the rf bank select and the CLIC threshold.
- `ret_pc`  out  PcWidth  resume PC; valid while `exit_ack`=1.
- `exit_ack`  out  1  one-cycle pulse: load `ret_pc` into the PC.
- `depth`  out  $clog2(Depth+1)  number of stacked frames.
- `full`  out  1  `depth == Depth`.
- `empty`  out  1  `depth == 0`.
- `err_order`  out  1  sticky: illegal entry (level not strictly above the running level, or push while full).
- `err_underflow`  out  1  sticky: `exit_req` while empty.

## Operation
- Storage: `Depth` frames of {level[PrioWidth], pc[PcWidth]} held as a LIFO with a write pointer equal to `depth`.
- Reset: `level_out`=0, `depth`=0, `ret_pc`=0, `exit_ack`=0, `err_order`=0, `err_underflow`=0. Frame contents are don't-care.
- Entry only (`entry_valid`=1, `exit_req`=0):
  - Legal when `entry_level > level_out` and not full.
  - Push {`level_out`, `entry_ret_pc`}, set `level_out` <= `entry_level`, increment `depth`.
  - Illegal: no state change except `err_order` <= 1.
- Exit only (`exit_req`=1, `entry_valid`=0):
  - Non-empty: pop the top frame; `ret_pc` <= top.pc, `level_out` <= top.level, `exit_ack` <= 1, decrement `depth`.
  - Empty: no state change, `exit_ack` stays 0, `err_underflow` <= 1.
- Simultaneous entry and exit (tail-chain):
  - Non-empty and `entry_level > top.level`: the stack is unchanged; the new ISR inherits the exiting ISR's return frame. `level_out` <= `entry_level`, `depth` unchanged, `exit_ack` stays 0, `entry_ret_pc` is ignored.
  - Otherwise (empty, or `entry_level <= top.level`): perform the exit-only behaviour and set `err_order` <= 1. The entry is dropped; the CLIC re-requests it later.
- Error flags clear only on `reset`.
- Arithmetic: `depth` never wraps; saturation is guaranteed by the full/empty guards.

## Timing
- All outputs are registered. An event sampled at edge N is visible after edge N.
- Entry latency: 1 cycle to `level_out`/`depth`.
- Exit latency: `exit_ack` and `ret_pc` are valid for exactly the one cycle after the edge that sampled `exit_req`. `level_out` is updated in that same cycle.
- Back-to-back operations are allowed every cycle. Each cycle sees the state left by the previous edge.
- Reset has priority over all inputs. Asserting it mid-nest discards all frames within one edge.

## Test plan
- Reset, then single entry level 3 with pc 0x1C, then exit two cycles later -> `level_out` goes 0->3->0; `exit_ack` pulses one cycle with `ret_pc`=0x1C; `depth` goes 0->1->0.
- Nest levels 2 (pc 0x10), 5 (pc 0x90), 7 (pc 0xA4), then three exits -> `ret_pc` reads 0xA4, 0x90, 0x10 in order; `level_out` reads 5, 2, 0; `full` never set for `Depth`=7.
- Entry level 2 while running level 4 -> state unchanged, `err_order`=1 and stays set across later legal operations.
- `exit_req` on an empty stack -> no `exit_ack`, `err_underflow`=1, `level_out` stays 0.
- Running level 3 over thread frame {0, 0x40}; assert exit and entry level 6 together -> `depth` stays 1, `level_out`=6, no `exit_ack`; the following exit gives `ret_pc`=0x40 and `level_out`=0.
- Push seven increasing levels 1..7 -> `full`=1; an eighth entry sets `err_order`; assert `reset` mid-nest -> all outputs return to reset values after one edge.

Source files
------------

// File: rtl/clic_exit_stack.sv
// Interrupt exit/nesting stack for the N-CLIC core: pushes the preempted level and resume PC
// on entry, pops them on ISR return, and supports tail-chaining when entry and return coincide.
module clic_exit_stack #(
    parameter int PrioWidth = 3,
    parameter int PcWidth   = 32,
    parameter int Depth     = 2**PrioWidth - 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         entry_valid,
    input  logic [PrioWidth-1:0]         entry_level,
    input  logic [PcWidth-1:0]           entry_ret_pc,
    input  logic                         exit_req,
    output logic [PrioWidth-1:0]         level_out,
    output logic [PcWidth-1:0]           ret_pc,
    output logic                         exit_ack,
    output logic [$clog2(Depth+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty,
    output logic                         err_order,
    output logic                         err_underflow
);
    localparam int DW = $clog2(Depth + 1);
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [PrioWidth-1:0] lvl_mem_r [Depth];
    logic [PcWidth-1:0]   pc_mem_r  [Depth];

    logic [PrioWidth-1:0] level_r;
    logic [PcWidth-1:0]   ret_pc_r;
    logic                 exit_ack_r;
    logic [DW-1:0]        depth_r;
    logic                 full_r;
    logic                 empty_r;
    logic                 err_order_r;
    logic                 err_underflow_r;

    logic                 is_empty_s;
    logic                 is_full_s;
    logic [DW-1:0]        depth_dec_s;
    logic [AW-1:0]        top_idx_s;
    logic [AW-1:0]        wr_idx_s;
    logic [PrioWidth-1:0] top_lvl_s;
    logic [PcWidth-1:0]   top_pc_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 chain_s;
    logic                 set_order_s;
    logic                 set_under_s;
    logic [DW-1:0]        depth_nx_s;

    assign is_empty_s  = (depth_r == {DW{1'b0}});
    assign is_full_s   = (depth_r == DW'(Depth));
    assign depth_dec_s = depth_r - DW'(1'b1);
    assign wr_idx_s    = depth_r[AW-1:0];

    // Top-of-stack lookup; index is pinned to 0 when empty so it never leaves the array.
    always_comb begin
        top_idx_s = {AW{1'b0}};
        if (is_empty_s) begin
            top_idx_s = {AW{1'b0}};
        end else begin
            top_idx_s = depth_dec_s[AW-1:0];
        end
        top_lvl_s = lvl_mem_r[top_idx_s];
        top_pc_s  = pc_mem_r[top_idx_s];
    end

    // Decode this cycle's operation; a rejected tail-chain degrades to a plain exit.
    always_comb begin
        push_s      = 1'b0;
        pop_s       = 1'b0;
        chain_s     = 1'b0;
        set_order_s = 1'b0;
        set_under_s = 1'b0;
        if (entry_valid && !exit_req) begin
            if ((entry_level > level_r) && !is_full_s) begin
                push_s = 1'b1;
            end else begin
                set_order_s = 1'b1;
            end
        end else if (exit_req && !entry_valid) begin
            if (!is_empty_s) begin
                pop_s = 1'b1;
            end else begin
                set_under_s = 1'b1;
            end
        end else if (entry_valid && exit_req) begin
            if (!is_empty_s && (entry_level > top_lvl_s)) begin
                chain_s = 1'b1;
            end else begin
                set_order_s = 1'b1;
                if (!is_empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    set_under_s = 1'b1;
                end
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Next stack depth.
    always_comb begin
        depth_nx_s = depth_r;
        if (push_s) begin
            depth_nx_s = depth_r + DW'(1'b1);
        end else if (pop_s) begin
            depth_nx_s = depth_dec_s;
        end else begin
            depth_nx_s = depth_r;
        end
    end

    // Frame storage; contents need no reset because depth gates every read.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            lvl_mem_r[wr_idx_s] <= level_r;
            pc_mem_r[wr_idx_s]  <= entry_ret_pc;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r         <= {PrioWidth{1'b0}};
            ret_pc_r        <= {PcWidth{1'b0}};
            exit_ack_r      <= 1'b0;
            depth_r         <= {DW{1'b0}};
            full_r          <= 1'b0;
            empty_r         <= 1'b1;
            err_order_r     <= 1'b0;
            err_underflow_r <= 1'b0;
        end else begin
            exit_ack_r      <= pop_s;
            depth_r         <= depth_nx_s;
            full_r          <= (depth_nx_s == DW'(Depth));
            empty_r         <= (depth_nx_s == {DW{1'b0}});
            err_order_r     <= err_order_r | set_order_s;
            err_underflow_r <= err_underflow_r | set_under_s;
            if (push_s || chain_s) begin
                level_r <= entry_level;
            end else if (pop_s) begin
                level_r  <= top_lvl_s;
                ret_pc_r <= top_pc_s;
            end
        end
    end

    assign level_out     = level_r;
    assign ret_pc        = ret_pc_r;
    assign exit_ack      = exit_ack_r;
    assign depth         = depth_r;
    assign full          = full_r;
    assign empty         = empty_r;
    assign err_order     = err_order_r;
    assign err_underflow = err_underflow_r;
endmodule
